// File: rtl/input_conditioner_pkg.sv
// Shared constants for the input conditioner: parameter defaults,
// legal ranges and the counter width helper.
package input_conditioner_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 16;

  localparam int DEBOUNCE_DEF = 4;
  localparam int DEBOUNCE_MIN = 1;
  localparam int DEBOUNCE_MAX = 255;

  localparam int STRETCH_DEF = 3;
  localparam int STRETCH_MIN = 0;
  localparam int STRETCH_MAX = 255;

  localparam int HOLD_DEF = 10;
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 65535;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioner channel: synchronizer, debounce, edge pulses,
// rise stretcher and long-press detector.
module cond_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_LEN = DEBOUNCE_DEF,
  parameter int STRETCH_LEN  = STRETCH_DEF,
  parameter int HOLD_LEN     = HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic stretched,
  output logic hold,
  output logic hold_pulse
);

  localparam int DW = cnt_w(DEBOUNCE_LEN);
  localparam int SW = cnt_w(STRETCH_LEN + 1);
  localparam int HW = cnt_w(HOLD_LEN + 1);

  localparam logic [DW-1:0] DB_TOP  = DW'(DEBOUNCE_LEN - 1);
  localparam logic [SW-1:0] ST_LOAD = SW'(STRETCH_LEN);
  localparam logic [HW-1:0] HD_TOP  = HW'(HOLD_LEN);

  logic          s1;
  logic          s;
  logic [DW-1:0] db_cnt;
  logic [SW-1:0] st_cnt;
  logic [HW-1:0] hd_cnt;

  logic          accept;
  logic          lvl_nx;
  logic [HW-1:0] hd_nx;

  always_comb begin
    accept = (s != level) && (db_cnt == DB_TOP);
    lvl_nx = accept ? s : level;
    // Counts the edge level rises, so cycle k of high reads k.
    hd_nx  = '0;
    if (lvl_nx) begin
      hd_nx = (hd_cnt == HD_TOP) ? hd_cnt : hd_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1         <= 1'b0;
      s          <= 1'b0;
      db_cnt     <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      st_cnt     <= '0;
      hd_cnt     <= '0;
      hold_pulse <= 1'b0;
    end else if (clr) begin
      s1         <= 1'b0;
      s          <= 1'b0;
      db_cnt     <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      st_cnt     <= '0;
      hd_cnt     <= '0;
      hold_pulse <= 1'b0;
    end else begin
      s1     <= in;
      s      <= s1;
      db_cnt <= (s == level || accept) ? '0 : db_cnt + DW'(1);
      level  <= lvl_nx;
      rise   <= accept & s;
      fall   <= accept & ~s;
      if (accept && s) begin
        st_cnt <= ST_LOAD;
      end else if (st_cnt != '0) begin
        st_cnt <= st_cnt - SW'(1);
      end
      hd_cnt     <= hd_nx;
      hold_pulse <= (hd_nx == HD_TOP) && (hd_cnt != HD_TOP);
    end
  end

  assign stretched = (st_cnt != '0);
  assign hold      = (hd_cnt == HD_TOP);

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: one cond_channel per input bit.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int CHANNELS     = CHANNELS_DEF,
  parameter int DEBOUNCE_LEN = DEBOUNCE_DEF,
  parameter int STRETCH_LEN  = STRETCH_DEF,
  parameter int HOLD_LEN     = HOLD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] stretched,
  output logic [CHANNELS-1:0] hold,
  output logic [CHANNELS-1:0] hold_pulse
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    cond_channel #(
      .DEBOUNCE_LEN(DEBOUNCE_LEN),
      .STRETCH_LEN (STRETCH_LEN),
      .HOLD_LEN    (HOLD_LEN)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in        (in[i]),
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .stretched (stretched[i]),
      .hold      (hold[i]),
      .hold_pulse(hold_pulse[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: default instance plus a
// fast-debounce instance used to reach the stretch retrigger case.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] in  = '0;
  logic [3:0] level, rise, fall, stretched, hold, hold_pulse;

  logic [0:0] fin = '0;
  logic [0:0] f_level, f_rise, f_fall, f_str, f_hold, f_hp;

  input_conditioner #(
    .CHANNELS(4), .DEBOUNCE_LEN(4), .STRETCH_LEN(3), .HOLD_LEN(10)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .in(in),
    .level(level), .rise(rise), .fall(fall),
    .stretched(stretched), .hold(hold), .hold_pulse(hold_pulse)
  );

  input_conditioner #(
    .CHANNELS(1), .DEBOUNCE_LEN(1), .STRETCH_LEN(3), .HOLD_LEN(2)
  ) dut_fast (
    .clk(clk), .rst(rst), .clr(clr), .in(fin),
    .level(f_level), .rise(f_rise), .fall(f_fall),
    .stretched(f_str), .hold(f_hold), .hold_pulse(f_hp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         dut;
    int         ch;
    logic [5:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {level, rise, fall, stretched, hold, hold_pulse}
  function automatic logic [5:0] obs(input int d, input int ch);
    if (d == 1)
      return {f_level[0], f_rise[0], f_fall[0], f_str[0], f_hold[0], f_hp[0]};
    return {level[ch], rise[ch], fall[ch], stretched[ch], hold[ch],
            hold_pulse[ch]};
  endfunction

  task automatic push(input int at, input int d, input int ch,
                      input logic [5:0] v);
    exp_t e;
    e.cyc = at;
    e.dut = d;
    e.ch  = ch;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk($sformatf("c%0d_d%0d_ch%0d", cyc, sb[i].dut, sb[i].ch),
            32'(obs(sb[i].dut, sb[i].ch)), 32'(sb[i].v));
        sb.delete(i);
      end
    end
  endtask

  // Channel stepped high at k=0, released at k=20, DEBOUNCE 4, HOLD 10.
  function automatic logic [5:0] press(input int k);
    if (k <= 5)  return 6'b000000;
    if (k == 6)  return 6'b110100;
    if (k <= 8)  return 6'b100100;
    if (k <= 14) return 6'b100000;
    if (k == 15) return 6'b100011;
    if (k <= 25) return 6'b100010;
    if (k == 26) return 6'b001000;
    return 6'b000000;
  endfunction

  // Channel high at 0, low at 6, high at 12.
  function automatic logic [5:0] twice(input int k);
    if (k <= 5)  return 6'b000000;
    if (k == 6)  return 6'b110100;
    if (k <= 8)  return 6'b100100;
    if (k <= 11) return 6'b100000;
    if (k == 12) return 6'b001000;
    if (k <= 17) return 6'b000000;
    if (k == 18) return 6'b110100;
    if (k <= 20) return 6'b100100;
    return 6'b100000;
  endfunction

  // Fast instance: in high at 0, low at 1, high at 2 onward.
  function automatic logic [5:0] retrig(input int k);
    case (k)
      3:       return 6'b110100;
      4:       return 6'b001100;
      5:       return 6'b110100;
      6:       return 6'b100111;
      7:       return 6'b100110;
      8:       return 6'b100010;
      default: return 6'b000000;
    endcase
  endfunction

  int t;

  initial begin
    repeat (3) step();
    for (int c = 0; c < 4; c++) chk($sformatf("rst_ch%0d", c), 32'(obs(0, c)), 0);
    chk("rst_fast", 32'(obs(1, 0)), 0);
    rst = 1'b1;
    step();

    // Simultaneous long press on ch0 and ch3
    t = cyc;
    in[0] = 1'b1;
    in[3] = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      push(t + k, 0, 0, press(k));
      push(t + k, 0, 3, press(k));
    end
    repeat (20) step();
    in[0] = 1'b0;
    in[3] = 1'b0;
    repeat (10) step();

    // Three-cycle glitch on ch1 is rejected
    t = cyc;
    in[1] = 1'b1;
    for (int k = 1; k <= 12; k++) push(t + k, 0, 1, 6'b000000);
    repeat (3) step();
    in[1] = 1'b0;
    repeat (10) step();

    // Two separate accepted rises on ch2
    t = cyc;
    in[2] = 1'b1;
    for (int k = 1; k <= 21; k++) push(t + k, 0, 2, twice(k));
    repeat (6) step();
    in[2] = 1'b0;
    repeat (6) step();
    in[2] = 1'b1;
    repeat (9) step();
    clr   = 1'b1;
    in[2] = 1'b0;
    push(cyc + 1, 0, 2, 6'b000000);
    step();
    clr = 1'b0;
    repeat (2) step();

    // Retrigger of the stretcher on the fast instance
    t = cyc;
    fin = 1'b1;
    for (int k = 1; k <= 8; k++) push(t + k, 1, 0, retrig(k));
    step();
    fin = 1'b0;
    step();
    fin = 1'b1;
    repeat (6) step();
    fin = 1'b0;
    repeat (3) step();

    // clr on the same edge as an accepted rise
    t = cyc;
    in[0] = 1'b1;
    for (int k = 1; k <= 11; k++) push(t + k, 0, 0, 6'b000000);
    push(t + 12, 0, 0, 6'b110100);
    repeat (5) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (6) step();

    // Asynchronous reset mid-count, release with inputs active
    in[1] = 1'b1;
    repeat (3) step();
    #3;
    rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) chk($sformatf("arst_ch%0d", c), 32'(obs(0, c)), 0);
    chk("arst_fast", 32'(obs(1, 0)), 0);
    repeat (2) step();
    rst = 1'b1;
    t = cyc;
    for (int k = 1; k <= 5; k++) begin
      push(t + k, 0, 0, 6'b000000);
      push(t + k, 0, 1, 6'b000000);
    end
    push(t + 6, 0, 0, 6'b110100);
    push(t + 6, 0, 1, 6'b110100);
    repeat (7) step();

    chk("sb_left", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
